// File: rtl/dromos_adder_pkg.sv
// Shared constants for the 65-bit prefix adder datapath.
// Stage count helper used by the pipelined prefix network.
package dromos_adder_pkg;

  localparam int WIDTH         = 65;
  localparam int PREFIX_LEVELS = 7;

  function automatic int num_stages(input int lps);
    return (PREFIX_LEVELS + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/prefix_network_pipe_65b_cell.sv
// Kogge-Stone dot operator: combines a high group with
// the adjacent low group into one (generate, propagate) pair.
module prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/prefix_network_pipe_65b.sv
// Pipelined 65-bit Kogge-Stone carry network with
// valid/ready flow control and bubble-collapsing stages.
module prefix_network_pipe_65b
  import dromos_adder_pkg::*;
#(
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [64:0] prop_i,
  input  logic [64:0] gen_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [64:0] carry_o,
  output logic [64:0] prop_o
);

  localparam int W  = WIDTH;
  localparam int NL = PREFIX_LEVELS;
  localparam int LS = LEVELS_PER_STAGE;
  localparam int NS = num_stages(LS);

  logic [W-1:0] lvl_g_in  [NL];
  logic [W-1:0] lvl_p_in  [NL];
  logic [W-1:0] lvl_g_out [NL];
  logic [W-1:0] lvl_p_out [NL];

  logic [NS-1:0] v_q;
  logic [NS-1:0] v_d;
  logic [NS-1:0] load_en;
  logic [W-1:0]  g_q  [NS];
  logic [W-1:0]  p_q  [NS];
  logic [W-1:0]  po_q [NS];
  logic [W-1:0]  g_d  [NS];
  logic [W-1:0]  p_d  [NS];
  logic [W-1:0]  po_d [NS];

  // A level reads the inputs, its stage register, or
  // the level just below it inside the same stage.
  for (genvar k = 0; k < NL; k++) begin : g_lvl
    localparam int D = 1 << k;
    if (k == 0) begin : g_src_in
      assign lvl_g_in[k] = gen_i;
      assign lvl_p_in[k] = prop_i;
    end else if ((k % LS) == 0) begin : g_src_reg
      assign lvl_g_in[k] = g_q[k/LS-1];
      assign lvl_p_in[k] = p_q[k/LS-1];
    end else begin : g_src_lvl
      assign lvl_g_in[k] = lvl_g_out[k-1];
      assign lvl_p_in[k] = lvl_p_out[k-1];
    end
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= D) begin : g_dot
        prefix_cell u_cell (
          .g_hi (lvl_g_in[k][i]),
          .p_hi (lvl_p_in[k][i]),
          .g_lo (lvl_g_in[k][i-D]),
          .p_lo (lvl_p_in[k][i-D]),
          .g    (lvl_g_out[k][i]),
          .p    (lvl_p_out[k][i])
        );
      end else begin : g_pass
        assign lvl_g_out[k][i] = lvl_g_in[k][i];
        assign lvl_p_out[k][i] = lvl_p_in[k][i];
      end
    end
  end

  // Each stage captures the output of its last level.
  for (genvar s = 0; s < NS; s++) begin : g_stg
    localparam int END = ((s + 1) * LS < NL) ? (s + 1) * LS : NL;
    assign g_d[s] = lvl_g_out[END-1];
    assign p_d[s] = lvl_p_out[END-1];
  end

  // Valid and original-propagate shift in from upstream.
  always_comb begin
    v_d[0]  = valid_i;
    po_d[0] = prop_i;
    for (int s = 1; s < NS; s++) begin
      v_d[s]  = v_q[s-1];
      po_d[s] = po_q[s-1];
    end
  end

  // A stage loads if it or any stage downstream of it
  // has a hole, or the output is being consumed.
  always_comb begin
    load_en = '0;
    for (int s = 0; s < NS; s++) begin
      load_en[s] = ready_i | (|((~v_q) >> s));
    end
  end

  // Stage registers; data only moves with a valid token.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int s = 0; s < NS; s++) begin
        g_q[s]  <= '0;
        p_q[s]  <= '0;
        po_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (load_en[s]) begin
          v_q[s] <= v_d[s];
          if (v_d[s]) begin
            g_q[s]  <= g_d[s];
            p_q[s]  <= p_d[s];
            po_q[s] <= po_d[s];
          end
        end
      end
    end
  end

  assign ready_o = load_en[0];
  assign valid_o = v_q[NS-1];
  assign carry_o = g_q[NS-1];
  assign prop_o  = po_q[NS-1];

  // Group propagate past the final level has no consumer.
  logic unused_p;
  assign unused_p = ^{lvl_p_out[NL-1], p_q[NS-1]};

endmodule

// File: tb/tb_prefix_network_pipe_65b.sv
// Scoreboard bench for the pipelined prefix network:
// default build plus LEVELS_PER_STAGE = 1, 3, 7 copies.
module tb_prefix_network_pipe_65b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [64:0] prop_i = '0;
  logic [64:0] gen_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [64:0] carry_o;
  logic [64:0] prop_o;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b1;
  logic [64:0] cur_exp = '0;

  logic [64:0] q_c [$];
  logic [64:0] q_p [$];
  int          q_t [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prefix_network_pipe_65b dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .prop_i  (prop_i),
    .gen_i   (gen_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .carry_o (carry_o),
    .prop_o  (prop_o)
  );

  task automatic chk(input string tag,
                     input logic [64:0] act,
                     input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [64:0] ripple(input logic [64:0] p,
                                         input logic [64:0] g);
    logic [64:0] c;
    c[0] = g[0];
    for (int i = 1; i < 65; i++) c[i] = g[i] | (p[i] & c[i-1]);
    return c;
  endfunction

  function automatic logic [64:0] rnd65();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[64:0];
  endfunction

  // Main scoreboard: compare the head every cycle valid_o
  // is up, pop only when it is consumed.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_c.delete();
      q_p.delete();
      q_t.delete();
    end else begin
      if (valid_o) begin
        if (q_c.size() == 0) begin
          chk("stale_out", 65'(valid_o), 65'd0);
        end else begin
          chk("carry", carry_o, q_c[0]);
          chk("prop", prop_o, q_p[0]);
          if (ready_i) begin
            if (lat_chk) chk("latency", 65'(cyc - q_t[0]), 65'd4);
            void'(q_c.pop_front());
            void'(q_p.pop_front());
            void'(q_t.pop_front());
          end
        end
      end
      if (valid_i && ready_o) begin
        q_c.push_back(cur_exp);
        q_p.push_back(prop_i);
        q_t.push_back(cyc);
      end
    end
  end

  for (genvar j = 0; j < 3; j++) begin : g_sw
    localparam int LPS = (j == 0) ? 1 : ((j == 1) ? 3 : 7);
    localparam int NSW = (7 + LPS - 1) / LPS;
    logic        rdy;
    logic        vo;
    logic [64:0] co;
    logic [64:0] po;
    logic [64:0] sq_c [$];
    logic [64:0] sq_p [$];
    int          sq_t [$];

    prefix_network_pipe_65b #(.LEVELS_PER_STAGE(LPS)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i (valid_i),
      .ready_o (rdy),
      .prop_i  (prop_i),
      .gen_i   (gen_i),
      .valid_o (vo),
      .ready_i (1'b1),
      .carry_o (co),
      .prop_o  (po)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        sq_c.delete();
        sq_p.delete();
        sq_t.delete();
      end else begin
        if (vo) begin
          if (sq_c.size() == 0) begin
            chk($sformatf("sw%0d_stale", LPS), 65'(vo), 65'd0);
          end else begin
            chk($sformatf("sw%0d_carry", LPS), co, sq_c[0]);
            chk($sformatf("sw%0d_prop", LPS), po, sq_p[0]);
            chk($sformatf("sw%0d_lat", LPS),
                65'(cyc - sq_t[0]), 65'(NSW));
            void'(sq_c.pop_front());
            void'(sq_p.pop_front());
            void'(sq_t.pop_front());
          end
        end
        if (valid_i && rdy) begin
          sq_c.push_back(ripple(prop_i, gen_i));
          sq_p.push_back(prop_i);
          sq_t.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [64:0] p,
                      input logic [64:0] g,
                      input logic [64:0] e);
    bit acc;
    int n;
    cur_exp = e;
    prop_i  = p;
    gen_i   = g;
    valid_i = 1'b1;
    acc = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 65'(acc), 65'd1);
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    prop_i  = rnd65();
    gen_i   = rnd65();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rnd(input int mode);
    logic [64:0] p;
    logic [64:0] g;
    if (mode == 0) begin
      p = rnd65();
      g = rnd65();
    end else begin
      p = rnd65() | rnd65() | rnd65();
      g = rnd65() & rnd65() & rnd65() & rnd65();
    end
    p[0] = 1'b0;
    send(p, g, ripple(p, g));
  endtask

  bit seen;
  int n_wait;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 65'(valid_o), 65'd0);
    chk("rst_carry", carry_o, 65'd0);
    chk("rst_prop", prop_o, 65'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 65'(ready_o), 65'd1);
    @(posedge clk);
    #1;

    send({64'hFFFF_FFFF_FFFF_FFFF, 1'b0}, 65'h1,
         65'h1_FFFF_FFFF_FFFF_FFFF);
    idle(6);
    send(65'h0, {64'h0, 1'b1}, 65'h1);
    idle(6);
    send({64'h7FFF_FFFF_FFFF_FFFF, 1'b0}, 65'h1,
         65'h0_FFFF_FFFF_FFFF_FFFF);
    idle(6);
    send({64'hFFFF_FFFF_FFFF_FFFF, 1'b0}, 65'h0, 65'h0);
    send(65'h0, 65'h1_0000_0000_0000_0002,
         65'h1_0000_0000_0000_0002);
    send({64'h0000_0000_FFFF_FFFF, 1'b0},
         65'h0_0000_0000_0000_0002,
         65'h0_0000_0001_FFFF_FFFE);
    idle(6);

    lat_chk = 1'b0;
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rnd(i % 2);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (7) begin
          @(posedge clk);
          #2;
          if (!ready_o && !seen) begin
            seen = 1'b1;
            chk("stall_fill", 65'(q_c.size()), 65'd4);
          end
        end
        ready_i = 1'b1;
      end
    join
    chk("stall_seen", 65'(seen), 65'd1);
    n_wait = 0;
    while (q_c.size() != 0 && n_wait < 50) begin
      @(posedge clk);
      n_wait++;
    end
    #1;
    chk("stall_drain", 65'(q_c.size()), 65'd0);
    idle(4);
    lat_chk = 1'b1;

    for (int i = 0; i < 3; i++) send_rnd(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 65'(valid_o), 65'd0);
    chk("mid_rst_carry", carry_o, 65'd0);
    chk("mid_rst_prop", prop_o, 65'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", 65'(ready_o), 65'd1);
    idle(10);
    chk("mid_rst_clean", 65'(q_c.size()), 65'd0);

    for (int i = 0; i < 1000; i++) send_rnd(i % 3 == 0 ? 0 : 1);
    idle(12);
    chk("end_main_q", 65'(q_c.size()), 65'd0);
    chk("end_sw1_q", 65'(g_sw[0].sq_c.size()), 65'd0);
    chk("end_sw3_q", 65'(g_sw[1].sq_c.size()), 65'd0);
    chk("end_sw7_q", 65'(g_sw[2].sq_c.size()), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prefix_network_pipe_65b.md
PREFIX_NETWORK_PIPE_65B -- requirements
Module: prefix_network_pipe_65b

Interface
REQ-001 The block SHALL have parameter LEVELS_PER_STAGE, default 2: prefix levels evaluated between pipeline registers; legal range 1..7.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port valid_i, input, 1 bit: upstream has a valid prop_i/gen_i vector.
REQ-005 The block SHALL have port ready_o, output, 1 bit: the block accepts an input vector this cycle.
REQ-006 The block SHALL have port prop_i, input, 65 bits: bit-level propagate from pre-processing; bit 0 is 0.
REQ-007 The block SHALL have port gen_i, input, 65 bits: bit-level generate from pre-processing; bit 0 is the carry-in.
REQ-008 The block SHALL have port valid_o, output, 1 bit: carry_o/prop_o hold a valid result.
REQ-009 The block SHALL have port ready_i, input, 1 bit: downstream (post-processing) accepts a result.
REQ-010 The block SHALL have port carry_o, output, 65 bits: group generate G[i:0] for each i; carry_o[i] is the carry into sum bit i; carry_o[64] is the carry-out.
REQ-011 The block SHALL have port prop_o, output, 65 bits: prop_i delayed to align with carry_o, for the sum XOR.

Function
REQ-012 The block SHALL implement a Kogge-Stone network of 7 levels k=0..6 with distance d=2^k.
REQ-013 At each level, for i>=d, the block SHALL compute G'[i]=G[i] | (P[i] & G[i-d]) and P'[i]=P[i] & P[i-d]; for i<d, G and P SHALL pass through unchanged.
REQ-014 The block SHALL have NUM_STAGES = ceil(7/LEVELS_PER_STAGE) register stages; the last stage SHALL register the outputs, and no combinational path SHALL run from any input to valid_o, carry_o or prop_o.
REQ-015 Latency SHALL be NUM_STAGES cycles from an accepted input to valid_o with the output stalled-free; the default latency is 4.
REQ-016 Transfers SHALL use valid/ready: input is accepted when valid_i & ready_o; output is consumed when valid_o & ready_i.
REQ-017 Stage n SHALL load when it is empty or stage n+1 loads/drains in the same cycle; ready_o SHALL equal the stage-0 load condition.
REQ-018 Throughput SHALL be one vector per cycle when ready_i is held high.
REQ-019 While valid_o & !ready_i, carry_o, prop_o and valid_o SHALL hold stable, and the pipeline SHALL fill without loss or duplication until ready_o deasserts.
REQ-020 Internal bubbles SHALL collapse: a stalled output SHALL not block the loading of empty upstream stages.
REQ-021 When the pipeline is full and ready_i rises, the block SHALL drain and accept in the same cycle, so ready_o is high that cycle.
REQ-022 When valid_i is low, the block SHALL inject no vector, and input data SHALL be ignored.
REQ-023 prop_o SHALL equal the original prop_i, not a group propagate.

Reset
REQ-024 While rst_ni=0, all stage valid bits, valid_o, carry_o and prop_o SHALL be 0, asynchronously.
REQ-025 ready_o SHALL be 1 in the first cycle after deassertion.
REQ-026 Reset mid-operation SHALL discard all in-flight vectors, with no output emitted for them.

Structure
REQ-027 Package dromos_adder_pkg SHALL hold the constants WIDTH=65 and PREFIX_LEVELS=7, and a function computing NUM_STAGES.
REQ-028 The dot operator SHALL be sub-module prefix_cell, with inputs (g_hi, p_hi, g_lo, p_lo) and outputs (g, p), instantiated per bit per level by generate loops.
REQ-029 Stage registers SHALL be a generate-indexed array; the level-to-stage mapping SHALL be derived from LEVELS_PER_STAGE only.

Verification
REQ-030 The bench SHALL cover: prop_i={64'hFFFF_FFFF_FFFF_FFFF,1'b0}, gen_i=65'h1, ready_i=1 -> after 4 cycles valid_o=1, carry_o=65'h1_FFFF_FFFF_FFFF_FFFF, prop_o=prop_i.
REQ-031 The bench SHALL cover: prop_i=0, gen_i={64'h0,1'b1} -> carry_o=65'h1, only bit 0 set, and carry_o[64]=0.
REQ-032 The bench SHALL cover: prop_i={64'h7FFF_FFFF_FFFF_FFFF,1'b0}, gen_i=65'h1 -> carry_o[63:0] all 1, carry_o[64]=0.
REQ-033 The bench SHALL cover a stall: 10 back-to-back vectors with ready_i=0 for cycles 3..9 -> ready_o falls after 4 accepted vectors, outputs stay stable, and all 10 results arrive in order with none lost or duplicated.
REQ-034 The bench SHALL cover reset: rst_ni pulsed low with 3 vectors in flight -> valid_o=0 immediately, no stale result after release, and ready_o=1.
REQ-035 The bench SHALL cover a parameter sweep: LEVELS_PER_STAGE=1,3,7 with 1000 random vectors -> carry_o matches the ripple-carry reference, at latency 7, 3 and 1.
